alu_vec_scheduler: RTL and testbench

- Shares one ALU lane (WIDTH-bit operands, 3-bit select, 2*WIDTH-bit result) among N_REQ requesters.
- Arbitrates, latches the winning operation, drives the ALU for one enable cycle, and waits a fixed ALU_LAT.
- Returns the result with the requester ID over a valid/ready response channel.
- Sits between the requesting control logic and one ALU instance inside the vector ALU datapath.

---
 rtl/alu_vec_scheduler.sv | 167 ++++++++++++++++
 tb/tb_alu_vec_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_vec_scheduler.sv
// alu_vec_scheduler: shares one ALU lane among N_REQ requesters.
// Arbitrates, latches the winning operation, pulses alu_enable for one
// cycle, waits ALU_LAT cycles, then returns the result with the owner ID
// over a valid/ready response channel.
// Optional macro ALU_SCHED_FIXED_PRIO_EN: lowest-index valid requester
// always wins and the round-robin pointer is removed. Default build is
// round-robin.
module alu_vec_scheduler #(
    parameter int WIDTH   = 4,
    parameter int N_REQ   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [WIDTH*N_REQ-1:0]     req_a,
    input  logic [WIDTH*N_REQ-1:0]     req_b,
    input  logic [3*N_REQ-1:0]         req_select,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic [2:0]                 alu_select,
    output logic                       alu_enable,
    input  logic [2*WIDTH-1:0]         alu_result,
    input  logic                       alu_inf,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [2*WIDTH-1:0]         rsp_data,
    output logic                       rsp_inf,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic                       busy
);

    localparam int IDW   = $clog2(N_REQ);
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [CNT_W-1:0]  lat_cnt;
    logic              grant_any;
    logic [IDW-1:0]    grant_idx;
    logic              accept;

`ifndef ALU_SCHED_FIXED_PRIO_EN
    logic [IDW-1:0]    rr_ptr;
`endif

    // Arbitration: first valid requester found searching upward from the start point
    always_comb begin
        int idx;
        int start;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
`ifdef ALU_SCHED_FIXED_PRIO_EN
        start     = 0;
`else
        start     = int'(rr_ptr);
`endif
        for (int k = 0; k < N_REQ; k++) begin
            idx = start + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // FSM next state and state-decoded outputs
    always_comb begin
        state_d    = state;
        req_ready  = '0;
        accept     = 1'b0;
        alu_enable = 1'b0;
        rsp_valid  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_any) begin
                    req_ready[grant_idx] = 1'b1;
                    accept               = 1'b1;
                    state_d              = ISSUE;
                end
            end
            ISSUE: begin
                alu_enable = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifndef ALU_SCHED_FIXED_PRIO_EN
    // Round-robin pointer moves just past the requester that was accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            if (grant_idx == IDW'(N_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_idx + 1'b1;
            end
        end
    end
`endif

    // Operation latch, latency counter and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_select <= '0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_inf    <= 1'b0;
            lat_cnt    <= '0;
        end else begin
            if (accept) begin
                alu_a      <= req_a[grant_idx*WIDTH +: WIDTH];
                alu_b      <= req_b[grant_idx*WIDTH +: WIDTH];
                alu_select <= req_select[grant_idx*3 +: 3];
                rsp_id     <= grant_idx;
            end
            if (state == ISSUE) begin
                lat_cnt <= CNT_W'(ALU_LAT - 1);
            end else if (state == WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (state == WAIT && lat_cnt == '0) begin
                rsp_data <= alu_result;
                rsp_inf  <= alu_inf;
            end
        end
    end

endmodule

// File: tb/tb_alu_vec_scheduler.sv
// Directed testbench for alu_vec_scheduler (WIDTH=4, N_REQ=4, ALU_LAT=1).
// A stub ALU registers {a,b} on enable and flags inf for select 3'b111.
// Build with ALU_SCHED_FIXED_PRIO_EN defined to expect fixed-priority grants.
module tb_alu_vec_scheduler;

    localparam int WIDTH   = 4;
    localparam int N_REQ   = 4;
    localparam int ALU_LAT = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        req_valid = '0;
    logic [3:0]        req_ready;
    logic [15:0]       req_a = '0;
    logic [15:0]       req_b = '0;
    logic [11:0]       req_select = '0;
    logic [3:0]        alu_a;
    logic [3:0]        alu_b;
    logic [2:0]        alu_select;
    logic              alu_enable;
    logic [7:0]        alu_result = '0;
    logic              alu_inf = 1'b0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [7:0]        rsp_data;
    logic              rsp_inf;
    logic [1:0]        rsp_id;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    int g_idx[8];
    int g_cyc[8];
    int g_n;
    int onehot_bad;

    alu_vec_scheduler #(
        .WIDTH   (WIDTH),
        .N_REQ   (N_REQ),
        .ALU_LAT (ALU_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_select (req_select),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_select (alu_select),
        .alu_enable (alu_enable),
        .alu_result (alu_result),
        .alu_inf    (alu_inf),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_inf    (rsp_inf),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Stub ALU: one-cycle registered result
    always_ff @(posedge clk) begin
        if (alu_enable) begin
            alu_result <= {alu_a, alu_b};
            alu_inf    <= (alu_select == 3'b111);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_rsp(input int max_cyc);
        int c;
        c = 0;
        while (!rsp_valid && c < max_cyc) begin
            step();
            c++;
        end
        chk("rsp_timeout", 32'(rsp_valid), 32'd1);
    endtask

    // Hold a request pattern with rsp_ready high and log every grant
    task automatic collect(input logic [3:0] v, input int ncyc);
        g_n        = 0;
        onehot_bad = 0;
        rsp_ready  = 1'b1;
        req_valid  = v;
        #1;
        for (int c = 0; c < ncyc; c++) begin
            if ($countones(req_ready) > 1) onehot_bad++;
            if (req_ready != 0 && g_n < 8) begin
                for (int b = 0; b < 4; b++) begin
                    if (req_ready[b]) g_idx[g_n] = b;
                end
                g_cyc[g_n] = c;
                g_n++;
            end
            step();
        end
        req_valid = '0;
        for (int c = 0; c < 6; c++) step();
    endtask

    task automatic check_grants(input string tag, input int e0, input int e1,
                                input int e2, input int e3, input int e4);
        int exp_idx[5];
        exp_idx = '{e0, e1, e2, e3, e4};
        chk({tag, "_count"}, 32'(g_n), 32'd5);
        chk({tag, "_onehot"}, 32'(onehot_bad), 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk({tag, "_idx"}, 32'(g_idx[i]), 32'(exp_idx[i]));
            if (i > 0) chk({tag, "_gap"}, 32'(g_cyc[i] - g_cyc[i-1]), 32'd4);
        end
    endtask

    initial begin
        int stall_bad;
        int early_rsp;

        // Lane payloads: a = 0x1..0x4 style defaults
        req_a      = 16'h4321;
        req_b      = 16'h8765;
        req_select = {3'b011, 3'b010, 3'b001, 3'b010};

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_alu_enable", 32'(alu_enable), 32'h0);
        chk("rst_alu_ops", 32'({alu_a, alu_b, alu_select}), 32'h0);
        chk("rst_rsp", 32'({rsp_data, rsp_inf, rsp_id}), 32'h0);

        // ---------------- single op ----------------
        req_a[3:0]      = 4'h3;
        req_b[3:0]      = 4'h5;
        req_select[2:0] = 3'b010;
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        #1;
        chk("single_ready_T", 32'(req_ready), 32'h1);
        chk("single_en_T", 32'(alu_enable), 32'h0);
        step();
        req_valid = '0;
        #1;
        chk("single_en_T1", 32'(alu_enable), 32'h1);
        chk("single_busy_T1", 32'(busy), 32'h1);
        chk("single_ops_T1", 32'({alu_a, alu_b, alu_select}), 32'({4'h3, 4'h5, 3'b010}));
        step();
        chk("single_en_T2", 32'(alu_enable), 32'h0);
        chk("single_vld_T2", 32'(rsp_valid), 32'h0);
        step();
        chk("single_vld_T3", 32'(rsp_valid), 32'h1);
        chk("single_data", 32'(rsp_data), 32'h35);
        chk("single_inf", 32'(rsp_inf), 32'h0);
        chk("single_id", 32'(rsp_id), 32'h0);
        step();
        chk("single_busy_T4", 32'(busy), 32'h0);
        chk("single_vld_T4", 32'(rsp_valid), 32'h0);

        // ---------------- round-robin, all requesting ----------------
        do_reset();
        collect(4'b1111, 20);
`ifdef ALU_SCHED_FIXED_PRIO_EN
        check_grants("arb_all", 0, 0, 0, 0, 0);
`else
        check_grants("arb_all", 0, 1, 2, 3, 0);
`endif

        // ---------------- two requesters 1 and 2 ----------------
        do_reset();
        collect(4'b0110, 20);
`ifdef ALU_SCHED_FIXED_PRIO_EN
        check_grants("arb_0110", 1, 1, 1, 1, 1);
`else
        check_grants("arb_0110", 1, 2, 1, 2, 1);
`endif

        // ---------------- backpressure ----------------
        do_reset();
        req_a[7:4]      = 4'hA;
        req_b[7:4]      = 4'hC;
        req_select[5:3] = 3'b001;
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        #1;
        chk("bp_first_ready", 32'(req_ready), 32'h2);
        step();
        wait_rsp(10);
        stall_bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== 8'hAC || rsp_id !== 2'd1 || req_ready !== 4'h0)
                stall_bad++;
            step();
        end
        chk("bp_stall_stable", 32'(stall_bad), 32'd0);
        chk("bp_data", 32'(rsp_data), 32'hAC);
        rsp_ready = 1'b1;
        #1;
        chk("bp_ready_in_done", 32'(req_ready), 32'h0);
        step();
        chk("bp_vld_drop", 32'(rsp_valid), 32'h0);
        chk("bp_reaccept", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        for (int c = 0; c < 4; c++) step();

        // ---------------- inf flag ----------------
        do_reset();
        req_a[11:8]      = 4'hF;
        req_b[11:8]      = 4'h1;
        req_select[8:6]  = 3'b111;
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        #1;
        chk("inf_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        wait_rsp(8);
        chk("inf_data", 32'(rsp_data), 32'hF1);
        chk("inf_flag", 32'(rsp_inf), 32'h1);
        chk("inf_id", 32'(rsp_id), 32'h2);
        step();

        // ---------------- reset mid-op ----------------
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b0010;
        #1;
        chk("rmo_accept", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        step();
        chk("rmo_in_wait", 32'({busy, alu_enable, rsp_valid}), 32'b100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rmo_outs_zero", 32'({alu_a, alu_b, alu_select, alu_enable, rsp_valid,
                                  rsp_data, rsp_inf, rsp_id, busy, req_ready}), 32'h0);
        early_rsp = 0;
        for (int c = 0; c < 5; c++) begin
            if (rsp_valid) early_rsp++;
            step();
        end
        chk("rmo_no_rsp", 32'(early_rsp), 32'd0);
        req_a[15:12] = 4'h7;
        req_b[15:12] = 4'h9;
        req_valid = 4'b1000;
        #1;
        chk("rmo_grant3", 32'(req_ready), 32'h8);
        step();
        req_valid = '0;
        wait_rsp(8);
        chk("rmo_rsp_id", 32'(rsp_id), 32'h3);
        chk("rmo_rsp_data", 32'(rsp_data), 32'h79);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
